// File: rtl/hd_stream_sink.sv
// Stream consumer: drives ready under a selectable backpressure policy, checks accepted
// words against an incrementing sequence, flags sender protocol violations, keeps counters.
module hd_stream_sink #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [7:0]            pattern,
  input  logic [DATA_WIDTH-1:0] expect_init,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_src,
  output logic                  ready_output,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic                  mismatch,
  output logic                  protocol_err,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFail = 2'd2
  } state_e;

  state_e                state_q;
  logic                  ready_q;
  logic [CNT_WIDTH-1:0]  beat_q;
  logic [CNT_WIDTH-1:0]  stall_q;
  logic [CNT_WIDTH-1:0]  err_q;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  mismatch_q;
  logic                  perr_q;
  logic [DATA_WIDTH-1:0] expected_q;
  logic [2:0]            idx_q;
  logic [15:0]           lfsr_q;
  logic                  stalled_q;
  logic [DATA_WIDTH-1:0] stall_data_q;

  logic        xfer;
  logic        stall_edge;
  logic        data_ok;
  logic        policy_ready;
  logic [15:0] lfsr_next;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign xfer       = valid & ready_q;
  assign stall_edge = valid & ~ready_q;
  assign data_ok    = (data_src == expected_q);
  // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_next  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    policy_ready = 1'b0;
    unique case (mode)
      2'd0: policy_ready = 1'b1;
      2'd1: policy_ready = 1'b0;
      2'd2: policy_ready = pattern[idx_q];
      2'd3: policy_ready = lfsr_q[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ready_q      <= 1'b0;
      beat_q       <= '0;
      stall_q      <= '0;
      err_q        <= '0;
      last_q       <= '0;
      mismatch_q   <= 1'b0;
      perr_q       <= 1'b0;
      expected_q   <= '0;
      idx_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      stalled_q    <= 1'b0;
      stall_data_q <= '0;
    end else begin
      mismatch_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q   <= 1'b0;
          stalled_q <= 1'b0;
          if (enable) begin
            state_q    <= StRun;
            expected_q <= expect_init;
            idx_q      <= '0;
            lfsr_q     <= LFSR_SEED;
          end
        end
        StRun: begin
          idx_q        <= idx_q + 3'd1;
          lfsr_q       <= lfsr_next;
          stalled_q    <= stall_edge;
          stall_data_q <= data_src;
          if (stall_edge) stall_q <= sat_inc(stall_q);
          // A stalled word must be held, with valid, until it is accepted.
          if (stalled_q && (!valid || (data_src != stall_data_q))) perr_q <= 1'b1;
          if (xfer) begin
            beat_q <= sat_inc(beat_q);
            last_q <= data_src;
            if (data_ok) begin
              expected_q <= expected_q + DATA_WIDTH'(1);
            end else begin
              err_q      <= sat_inc(err_q);
              mismatch_q <= 1'b1;
              expected_q <= data_src + DATA_WIDTH'(1);
            end
          end
          if (xfer && !data_ok && STOP_ON_ERR) begin
            state_q <= StFail;
            ready_q <= 1'b0;
          end else if (!enable) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
          end else begin
            ready_q <= policy_ready;
          end
        end
        default: begin
          ready_q   <= 1'b0;
          stalled_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_output = ready_q;
  assign beat_count   = beat_q;
  assign stall_count  = stall_q;
  assign error_count  = err_q;
  assign last_data    = last_q;
  assign mismatch     = mismatch_q;
  assign protocol_err = perr_q;
  assign state        = state_q;

endmodule

// File: doc/hd_stream_sink.md
Name: hd_stream_sink

Overview:
Receiving end of the team's valid/ready handshake stream. It is the consumer placed after an HD / HD_COMPART register slice. It drives ready back upstream under a selectable backpressure policy and checks each accepted word against an incrementing expected sequence. It also checks the sender for protocol violations and keeps saturating beat, stall and error counters for bench and bring-up use.

Parameters:
DATA_WIDTH, 16, width of stream data
CNT_WIDTH, 16, width of each statistics counter
LFSR_SEED, 16'hACE1, reset/load value of the 16-bit backpressure LFSR; must be nonzero
STOP_ON_ERR, 1, 1 = enter FAIL on the first data mismatch; 0 = keep running and count errors

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
enable  input  1  1 = run the sink; 0 = return to IDLE
mode  input  2  ready policy: 0 always, 1 never, 2 pattern, 3 LFSR
pattern  input  8  ready pattern for mode 2, bit 0 used first
expect_init  input  DATA_WIDTH  first expected data word, loaded on IDLE->RUN
valid  input  1  upstream data valid
data_src  input  DATA_WIDTH  upstream data
ready_output  output  1  sink ready, registered
beat_count  output  CNT_WIDTH  accepted transfers
stall_count  output  CNT_WIDTH  cycles with valid=1 and ready_output=0 in RUN
error_count  output  CNT_WIDTH  data mismatches
last_data  output  DATA_WIDTH  most recently accepted word
mismatch  output  1  one-cycle pulse, the cycle after a bad beat is accepted
protocol_err  output  1  sticky sender-violation flag
state  output  2  IDLE=0, RUN=1, FAIL=2

Behaviour:
- Timing: all logic on posedge clk. rst is synchronous, active-high and has priority over everything else, including mid-transfer and in FAIL.
- Reset values: ready_output=0, all counters=0, last_data=0, mismatch=0, protocol_err=0, state=IDLE, LFSR=LFSR_SEED, pattern index=0, expected=0.
- Handshake: a transfer happens at a posedge where valid=1 and ready_output=1. ready_output is a flop and never depends combinationally on valid or data_src.
- IDLE:
  - ready_output=0; counters hold.
  - enable=1 -> RUN next cycle; expected<=expect_init, pattern index<=0, LFSR<=LFSR_SEED.
- RUN, next-cycle ready_output by mode:
  - mode 0: 1.
  - mode 1: 0.
  - mode 2: pattern[idx]; idx advances by 1 every RUN cycle, wrapping 7->0.
  - mode 3: LFSR bit 0. LFSR is Fibonacci, taps 16,14,13,11, and steps every RUN cycle.
  - Mode changes take effect on the next ready_output update; no flush.
- First RUN cycle: ready_output is still 0 because of the register. Policy-driven ready appears from the second RUN cycle.
- RUN, enable=0: -> IDLE next cycle, ready_output<=0. A transfer that completes at that same edge is still counted and checked.
- Accepted beat:
  - beat_count+1 and last_data<=data_src.
  - If data_src==expected: expected<=expected+1, wrapping modulo 2^DATA_WIDTH (FFFF -> 0000).
  - Else: error_count+1, mismatch=1 next cycle, expected<=data_src+1 (resynchronise). If STOP_ON_ERR=1 -> FAIL.
- FAIL: ready_output=0; counters and last_data frozen; leaves only on rst; enable is ignored.
- stall_count: +1 each RUN cycle with valid=1 and ready_output=0.
- Counters: saturate at all-ones; no wrap.
- Protocol check (RUN only): a stall edge is one with valid=1 and ready_output=0. If the next edge has valid=0, or data_src differs from the stalled value, set protocol_err. It stays set until rst.
- Simultaneous events: enable falling at the same edge as a bad beat with STOP_ON_ERR=1 -> FAIL wins.

Test Plan:
- rst, enable=1, mode 0, expect_init=1, sender streams 1..5 back-to-back -> ready_output=1 from the 2nd RUN cycle; beat_count=5, error_count=0, last_data=5.
- mode 2, pattern=8'b0000_0101, sender holds valid=1 continuously -> ready_output repeats 1,0,1,0,0,0,0,0; beat_count +2 and stall_count +6 per 8 cycles.
- Sender sends 1,2,4 with STOP_ON_ERR=1 -> mismatch pulses once, error_count=1, state=FAIL, ready_output=0; toggling enable has no effect; rst clears everything.
- STOP_ON_ERR=0, sends 1,2,4,5 -> error_count=1, no further errors; expected resynchronises to 5 then 6.
- mode 1, sender raises valid with data 3 then drops valid after 2 cycles -> stall_count=2, protocol_err=1 and stays set. Repeat with data changed 3->7 while stalled -> protocol_err=1.
- expect_init=16'hFFFE, mode 3, stream FFFE,FFFF,0000,0001 -> error_count=0, beat_count=4. Assert rst mid-stream with valid=1 -> all outputs return to reset values on the next edge.
